// File: rtl/elementary_ca_engine.sv
// elementary_ca_engine
//   One-dimensional elementary cellular automaton. A run of N generations is
//   launched with start; the rule, boundary mode and step count are captured
//   when the run begins, so they may change freely while it is in progress.
//
// Ports
//   clk        sole clock, all state updates on posedge
//   areset     asynchronous active-high reset
//   load       synchronous load of data into q (priority over start, aborts a run)
//   data       load value
//   rule       Wolfram rule number (captured at start)
//   bound      boundary mode (captured at start): 00 zero, 01 one, 10 wrap, 11 edge-copy
//   start      begin a run of 'steps' generations
//   steps      generation count for the run (captured at start)
//   q          current cell state, registered
//   busy       high while a run is in progress
//   done       one-cycle pulse at run completion
//   gen_count  generations computed since last load or reset, wraps
module elementary_ca_engine #(
   parameter int unsigned WIDTH = 512,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic [7:0]       rule,
   input  logic [1:0]       bound,
   input  logic             start,
   input  logic [CNT_W-1:0] steps,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] gen_count
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [7:0]       rule_r;
   logic [1:0]       bound_r;
   logic [CNT_W-1:0] remaining;

   logic             capture;
   logic             step;
   logic             done_nxt;

   logic             left_in;
   logic             right_in;
   logic [WIDTH+1:0] ext;
   logic [WIDTH-1:0] q_nxt;

   // Neighbours that fall outside the array: left_in sits above q[WIDTH-1],
   // right_in sits below q[0].
   always_comb begin
      left_in  = 1'b0;
      right_in = 1'b0;
      case (bound_r)
         2'b01: begin
            left_in  = 1'b1;
            right_in = 1'b1;
         end
         2'b10: begin
            left_in  = q[0];
            right_in = q[WIDTH-1];
         end
         2'b11: begin
            left_in  = q[WIDTH-1];
            right_in = q[0];
         end
         default: begin
            left_in  = 1'b0;
            right_in = 1'b0;
         end
      endcase
   end

   assign ext = {left_in, q, right_in};

   // ext[i+2:i] is {l, c, r} for cell i, which directly indexes the rule.
   always_comb begin
      q_nxt = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         q_nxt[i] = rule_r[ext[i +: 3]];
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      step      = 1'b0;
      done_nxt  = 1'b0;
      if (load) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (steps == '0) begin
                     done_nxt = 1'b1;
                  end else begin
                     capture   = 1'b1;
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               step = 1'b1;
               if (remaining == CNT_W'(1)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         q         <= '0;
         done      <= 1'b0;
         gen_count <= '0;
         rule_r    <= '0;
         bound_r   <= '0;
         remaining <= '0;
      end else begin
         done <= done_nxt;
         if (load) begin
            q         <= data;
            gen_count <= '0;
         end else begin
            if (capture) begin
               rule_r    <= rule;
               bound_r   <= bound;
               remaining <= steps;
            end
            if (step) begin
               q         <= q_nxt;
               gen_count <= gen_count + CNT_W'(1);
               remaining <= remaining - CNT_W'(1);
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: doc/elementary_ca_engine.md
ELEMENTARY_CA_ENGINE -- requirements
Module: elementary_ca_engine

Interface
REQ-001 SHALL provide parameter WIDTH, default 512, number of cells (min 4).
REQ-002 SHALL provide parameter CNT_W, default 16, width of step and generation counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  synchronous load of data into q.
REQ-006 SHALL have port data  input  WIDTH  load value.
REQ-007 SHALL have port rule  input  8  Wolfram rule number, captured at start.
REQ-008 SHALL have port bound  input  2  boundary mode, captured at start: 00 zero, 01 one, 10 wrap, 11 edge-copy.
REQ-009 SHALL have port start  input  1  begin a run of steps generations.
REQ-010 SHALL have port steps  input  CNT_W  generation count for the run, captured at start.
REQ-011 SHALL have port q  output  WIDTH  current cell state, registered.
REQ-012 SHALL have port busy  output  1  high while a run is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at run completion.
REQ-014 SHALL have port gen_count  output  CNT_W  generations computed since last load or reset, wraps modulo 2^CNT_W.

Function
REQ-015 SHALL define neighbours of cell i as l=q[i+1], c=q[i], r=q[i-1]; next q[i] = rule_r[{l,c,r}] (rule_r = captured rule).
REQ-016 SHALL supply out-of-range neighbours per captured bound: zero -> 0; one -> 1; wrap -> l of q[WIDTH-1] is q[0], r of q[0] is q[WIDTH-1]; edge-copy -> missing neighbour equals the edge cell itself.
REQ-017 SHALL implement FSM with states IDLE and RUN; busy = (state == RUN).
REQ-018 SHALL, in IDLE with start=1, load=0, steps=N>0: capture rule, bound, N; enter RUN; q unchanged on that edge.
REQ-019 SHALL, in RUN, compute one generation per clock, increment gen_count per generation, decrement remaining count; after the Nth generation return to IDLE with done=1 for exactly one cycle.
REQ-020 SHALL give latency: start sampled at edge k -> generations applied at edges k+1..k+N; busy high after edges k..k+N-1; done high after edge k+N only.
REQ-021 SHALL, on start with steps=0 in IDLE, leave q and gen_count unchanged, keep busy low, pulse done on the next cycle.
REQ-022 SHALL ignore start while in RUN; changes to rule, bound, steps during RUN SHALL NOT affect the run.
REQ-023 SHALL give load priority over start in any state: q<=data, gen_count<=0, state<=IDLE, busy low, no done pulse (aborts an active run).
REQ-024 SHALL hold q constant whenever IDLE and load=0.
REQ-025 SHALL, when start is sampled on the same edge that ends a run (done rising), ignore that start.

Reset
REQ-026 SHALL on areset=1, immediately and independent of clk: q=0, busy=0, done=0, gen_count=0, state=IDLE, captured rule=0, bound=00, remaining=0.
REQ-027 SHALL, on areset asserted mid-run, abandon the run with no done pulse; first run after release requires a new start.

Verification
REQ-028 SHALL check: WIDTH=512, load data=1, start rule=110 bound=00 steps=1 -> q=0x3, done pulse, gen_count=1.
REQ-029 SHALL check: WIDTH=8, load 8'h01, rule=90 bound=10 steps=1 -> q=8'h82; steps=4 from 8'h01 matches software model each cycle.
REQ-030 SHALL check: WIDTH=8, load 8'h00, rule=0xF0 bound=01 steps=3 -> q=8'hE0, busy high exactly 3 cycles; rule=0xCC bound=11 any steps -> q unchanged.
REQ-031 SHALL check: start steps=10, load asserted after 4 generations -> q=data, gen_count=0, busy low, no done pulse.
REQ-032 SHALL check: start steps=0 -> done pulse next cycle, busy never high, q unchanged; start during RUN ignored (total generations = first steps only).
REQ-033 SHALL check: areset asserted between clock edges mid-run -> q=0, busy=0, gen_count=0 before next posedge; no done pulse.
